// File: rtl/mips_fetch.sv
`default_nettype none
// ============================================================================
// Module   : mips_fetch
// Purpose  : MIPS instruction-fetch stage. It fetches one word at a time from
//            instruction memory and holds it for decode until retire. It also
//            computes the next PC for sequential, branch, j/jal and jr flow.
// Options  : MIPS_FETCH_ALIGN_CHK_EN - when defined, a misaligned next PC sets
//            a sticky error flag and parks the stage in ERR until reset.
//            When undefined, the low two bits of the next PC are cleared.
// Revision : 1.0 - initial release
// ============================================================================
module mips_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    // Instruction memory
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    // Decode side
    output logic [31:0] instr_out,
    output logic [5:0]  op_out,
    output logic [5:0]  func_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4_out,
    output logic        instr_valid,
    input  logic        stall_in,
    input  logic        branch_in,
    input  logic        jump_in,
    input  logic        zero_in,
    input  logic [31:0] rs_data_in,
    output logic        align_err_out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2
`ifdef MIPS_FETCH_ALIGN_CHK_EN
        ,
        ST_ERR   = 2'd3
`endif
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_valid;
    logic        r_req;

    logic [31:0] w_pc_plus4;
    logic [5:0]  w_op;
    logic [5:0]  w_func;
    logic        w_is_jr;
    logic        w_is_j;
    logic        w_br_taken;
    logic [31:0] w_br_off;
    logic [31:0] w_next_pc;
    logic        w_retire;

    // Decode fields and arithmetic come only from held state, never from imem_rdata
    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_op       = r_instr[31:26];
    assign w_func     = r_instr[5:0];
    assign w_is_jr    = jump_in && (w_op == 6'h00) && (w_func == 6'h08);
    assign w_is_j     = jump_in && ((w_op == 6'h02) || (w_op == 6'h03));
    // A single zero_in polarity flip covers both beq and bne
    assign w_br_taken = branch_in && (zero_in ^ (w_op == 6'h05));
    assign w_br_off   = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
    assign w_retire   = (r_state == ST_VALID) && !stall_in;

    // Next-PC select: jr > j/jal > taken branch > sequential
    always_comb begin
        w_next_pc = w_pc_plus4;
        if (w_is_jr) begin
            w_next_pc = rs_data_in;
        end else if (w_is_j) begin
            w_next_pc = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
        end else if (w_br_taken) begin
            w_next_pc = w_pc_plus4 + w_br_off;
        end
    end

`ifdef MIPS_FETCH_ALIGN_CHK_EN
    logic r_align_err;
    logic w_misaligned;

    assign w_misaligned  = |w_next_pc[1:0];
    assign align_err_out = r_align_err;

    // Fetch FSM with alignment trap; ERR is left only through reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_pc        <= RESET_PC;
            r_instr     <= 32'h0000_0000;
            r_valid     <= 1'b0;
            r_req       <= 1'b0;
            r_align_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_FETCH;
                    r_req   <= 1'b1;
                end
                ST_FETCH: begin
                    if (imem_ready) begin
                        r_instr <= imem_rdata;
                        r_valid <= 1'b1;
                        r_req   <= 1'b0;
                        r_state <= ST_VALID;
                    end
                end
                ST_VALID: begin
                    if (w_retire) begin
                        r_valid <= 1'b0;
                        if (w_misaligned) begin
                            r_align_err <= 1'b1;
                            r_req       <= 1'b0;
                            r_state     <= ST_ERR;
                        end else begin
                            r_pc    <= w_next_pc;
                            r_req   <= 1'b1;
                            r_state <= ST_FETCH;
                        end
                    end
                end
                ST_ERR: begin
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end
`else
    logic [31:0] w_next_pc_al;

    // The low bits are dropped so every fetch address stays word aligned
    assign w_next_pc_al  = w_next_pc & 32'hFFFF_FFFC;
    assign align_err_out = 1'b0;

    // Fetch FSM: IDLE -> FETCH -> VALID -> FETCH ...
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_PC;
            r_instr <= 32'h0000_0000;
            r_valid <= 1'b0;
            r_req   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_FETCH;
                    r_req   <= 1'b1;
                end
                ST_FETCH: begin
                    if (imem_ready) begin
                        r_instr <= imem_rdata;
                        r_valid <= 1'b1;
                        r_req   <= 1'b0;
                        r_state <= ST_VALID;
                    end
                end
                ST_VALID: begin
                    if (w_retire) begin
                        r_pc    <= w_next_pc_al;
                        r_valid <= 1'b0;
                        r_req   <= 1'b1;
                        r_state <= ST_FETCH;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end
`endif

    assign imem_req     = r_req;
    assign imem_addr    = r_pc;
    assign pc_out       = r_pc;
    assign pc_plus4_out = w_pc_plus4;
    assign instr_out    = r_instr;
    assign op_out       = w_op;
    assign func_out     = w_func;
    assign instr_valid  = r_valid;

endmodule
`default_nettype wire

// File: doc/mips_fetch.md
MIPS_FETCH -- requirements
Module: mips_fetch

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: imem_req  output  1  instruction-memory read request.
REQ-005 SHALL have port: imem_addr  output  32  word address of the fetch; always equal to pc_out.
REQ-006 SHALL have port: imem_ready  input  1  imem_rdata valid this cycle.
REQ-007 SHALL have port: imem_rdata  input  32  fetched instruction word.
REQ-008 SHALL have port: instr_out  output  32  held instruction for decode.
REQ-009 SHALL have ports: op_out / func_out  output  6 / 6  instr_out[31:26] / instr_out[5:0], driving the control decoder.
REQ-010 SHALL have ports: pc_out / pc_plus4_out  output  32 / 32  PC of held instruction / pc_out+4.
REQ-011 SHALL have port: instr_valid  output  1  instr_out holds an unretired instruction.
REQ-012 SHALL have port: stall_in  input  1  downstream hold; instruction not retired while high.
REQ-013 SHALL have ports: branch_in, jump_in, zero_in  input  1 each  decoder branch/jump outputs and ALU zero flag for the held instruction.
REQ-014 SHALL have port: rs_data_in  input  32  register rs value (jr target).
REQ-015 SHALL have port: align_err_out  output  1  sticky misaligned-target flag.

Function
REQ-016 SHALL implement states IDLE, FETCH, VALID, ERR; ERR is reachable only with MIPS_FETCH_ALIGN_CHK_EN defined.
REQ-017 IDLE: imem_req=0; SHALL move to FETCH on the next edge after reset release.
REQ-018 FETCH: imem_req=1; on imem_ready=1 SHALL capture imem_rdata into instr_out, set instr_valid=1, enter VALID; imem_ready=0 keeps FETCH indefinitely.
REQ-019 imem_ready while not in FETCH SHALL be ignored.
REQ-020 VALID: imem_req=0; retire occurs on an edge where stall_in=0; stall_in=1 SHALL hold instr_out, pc_out, instr_valid unchanged.
REQ-021 On retire, pc_out SHALL load next_pc, instr_valid clears, state goes to FETCH; fetch-to-fetch throughput is therefore 2 cycles minimum with zero-wait memory.
REQ-022 next_pc priority: jr (jump_in=1, op=0, func=8) -> rs_data_in; j/jal (jump_in=1, op=2 or 3) -> {pc_plus4[31:28], instr[25:0], 2'b00}; taken branch -> pc_plus4 + (sign-extended instr[15:0] << 2); else pc_plus4.
REQ-023 Branch taken SHALL equal branch_in AND (zero_in XOR (op==6'h05)), covering beq and bne.
REQ-024 All PC arithmetic SHALL be modulo 2^32; pc_out=32'hFFFF_FFFC sequential retire wraps to 32'h0000_0000.
REQ-025 jal with jump_in=0 SHALL fall through to pc_plus4 (decoder-driven, no override).
REQ-026 No outputs SHALL depend combinationally on imem_rdata; op_out/func_out change only with instr_out.

Reset
REQ-027 rst_n low SHALL immediately force state=IDLE, pc_out=RESET_PC, instr_out=0 (op/func = nop), instr_valid=0, imem_req=0, align_err_out=0.
REQ-028 Reset asserted mid-FETCH SHALL abandon the request; a late imem_ready after release SHALL be ignored until FETCH is re-entered.

Configuration
REQ-029 Macro MIPS_FETCH_ALIGN_CHK_EN defined: retire with next_pc[1:0]!=0 SHALL set align_err_out=1, leave pc_out unchanged, enter ERR; ERR holds imem_req=0, instr_valid=0 until reset.
REQ-030 Macro undefined: next_pc[1:0] SHALL be forced to 2'b00, align_err_out tied 0, ERR state absent.

Verification
REQ-031 Reset release, imem_ready=1 always, no branches -> imem_addr 0x0,0x4,0x8 on successive FETCH cycles, instr_valid high every other cycle.
REQ-032 pc=0x100, instr beq with imm 0xFFFF, branch_in=1, zero_in=1 -> next pc_out=0x100; zero_in=0 -> 0x104; bne (op 5), zero_in=0 -> 0x100.
REQ-033 pc=0x3000_0000, instr j 0x0000040 with jump_in=1 -> pc_out=0x3000_0100; jr with rs_data_in=0x0000_2000 -> pc_out=0x2000.
REQ-034 stall_in=1 for 5 cycles in VALID plus imem_ready delayed 3 cycles in FETCH -> instr_out/pc_out stable throughout, no double retire, no missed instruction.
REQ-035 jr with rs_data_in=0x0000_2002 -> with macro: align_err_out=1, imem_req stays 0, pc_out unchanged; without: pc_out=0x2000.
REQ-036 rst_n pulsed low mid-FETCH at pc=0x40 -> outputs at reset values asynchronously, next fetch at RESET_PC.
